usbf_dma_arb: RTL and testbench

- Round-robin arbiter that shares one external DMA channel among NUM_EP endpoint register files.
- Collects each endpoint's dma_req, grants one endpoint at a time, and routes the external dma_ack back to the granted endpoint only.
- Limits each grant to a burst of BURST_MAX acks so that no endpoint can starve the others.
- Runs in the bus clock domain, the same domain as the endpoint files' DMA request/ack logic.

---
 rtl/usbf_dma_arb.sv | 142 ++++++++++++++
 tb/tb_usbf_dma_arb.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/usbf_dma_arb.sv
// Round-robin arbiter sharing one external DMA channel among NUM_EP endpoint files.
// Optional macro USBF_DMA_ARB_EP0_PRIO_EN gives endpoint 0 absolute priority in IDLE.
module usbf_dma_arb #(
    parameter int unsigned NUM_EP    = 4,
    parameter int unsigned BURST_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arb_en,
    input  logic [NUM_EP-1:0] ep_dma_req,
    output logic [NUM_EP-1:0] ep_dma_ack,
    output logic              dma_req,
    input  logic              dma_ack,
    output logic [3:0]        dma_ch,
    output logic              busy
);

    localparam int unsigned CNT_W = (BURST_MAX == 0) ? 1 : $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = (BURST_MAX == 0) ? '0 : CNT_W'(BURST_MAX - 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] GRANT   = 2'd1;
    localparam logic [1:0] XFER    = 2'd2;
    localparam logic [1:0] RELEASE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [3:0]       ch_q, ch_d;
    logic [3:0]       last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             prio_q, prio_d;

    logic             rr_hit;
    logic [3:0]       rr_idx;
    logic [4:0]       scan_idx;
    logic             req_sel;
    logic [NUM_EP-1:0] ack_vec;
    logic             burst_done;

    // Scan from last+1 upward with wrap; first active requester wins.
    always_comb begin
        rr_hit   = 1'b0;
        rr_idx   = '0;
        scan_idx = '0;
        for (int unsigned i = 1; i <= NUM_EP; i++) begin
            scan_idx = {1'b0, last_q} + 5'(i);
            if (scan_idx >= 5'(NUM_EP)) begin
                scan_idx = scan_idx - 5'(NUM_EP);
            end
            for (int unsigned j = 0; j < NUM_EP; j++) begin
                if (!rr_hit && scan_idx == 5'(j) && ep_dma_req[j]) begin
                    rr_hit = 1'b1;
                    rr_idx = 4'(j);
                end
            end
        end
    end

    // Request of the granted endpoint, and ack routing only while transferring.
    always_comb begin
        req_sel = 1'b0;
        ack_vec = '0;
        for (int unsigned j = 0; j < NUM_EP; j++) begin
            if (ch_q == 4'(j)) begin
                req_sel    = ep_dma_req[j];
                ack_vec[j] = dma_ack && (state_q == XFER);
            end
        end
    end

    assign burst_done = (BURST_MAX != 0) && dma_ack && (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        prio_d  = prio_q;
        case (state_q)
            IDLE: begin
                if (arb_en && |ep_dma_req) begin
`ifdef USBF_DMA_ARB_EP0_PRIO_EN
                    if (ep_dma_req[0]) begin
                        ch_d   = '0;
                        prio_d = 1'b1;
                    end else begin
                        ch_d   = rr_idx;
                        prio_d = 1'b0;
                    end
`else
                    ch_d   = rr_idx;
                    prio_d = 1'b0;
`endif
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                state_d = XFER;
            end
            XFER: begin
                if (dma_ack) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (!req_sel || !arb_en || burst_done) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                // A priority grant leaves the rotation pointer untouched.
                if (!prio_q) begin
                    last_d = ch_q;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ch_q    <= '0;
            last_q  <= 4'(NUM_EP - 1);
            cnt_q   <= '0;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            prio_q  <= prio_d;
        end
    end

    assign dma_req    = (state_q == XFER);
    assign busy       = (state_q != IDLE);
    assign dma_ch     = ch_q;
    assign ep_dma_ack = ack_vec;

endmodule

// File: tb/tb_usbf_dma_arb.sv
// Directed bench for usbf_dma_arb (NUM_EP=4, BURST_MAX=8); honours USBF_DMA_ARB_EP0_PRIO_EN.
module tb_usbf_dma_arb;

    logic       clk;
    logic       rst;
    logic       arb_en;
    logic [3:0] ep_dma_req;
    logic [3:0] ep_dma_ack;
    logic       dma_req;
    logic       dma_ack;
    logic [3:0] dma_ch;
    logic       busy;

    int checks = 0;
    int errors = 0;

    usbf_dma_arb #(.NUM_EP(4), .BURST_MAX(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .arb_en     (arb_en),
        .ep_dma_req (ep_dma_req),
        .ep_dma_ack (ep_dma_ack),
        .dma_req    (dma_req),
        .dma_ack    (dma_ack),
        .dma_ch     (dma_ch),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_dma_req", {31'd0, dma_req}, 0);
        chk("rst_dma_ch", {28'd0, dma_ch}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_ep_ack", {28'd0, ep_dma_ack}, 0);
        cyc();
        rst = 1'b1;
    endtask

    initial begin
        int starts, ends, low, acks, n;
        logic prev;
        logic [3:0] exp_ch;

        rst = 1'b0; arb_en = 1'b1; ep_dma_req = 4'b0000; dma_ack = 1'b0;
        cyc();
        do_reset();

        // Single requester ep2
        ep_dma_req = 4'b0100;
        cyc();
        chk("t1_grant_ch", {28'd0, dma_ch}, 2);
        chk("t1_grant_req", {31'd0, dma_req}, 0);
        chk("t1_grant_busy", {31'd0, busy}, 1);
        cyc();
        chk("t1_xfer_req", {31'd0, dma_req}, 1);
        dma_ack = 1'b1; #1;
        chk("t1_ack_route", {28'd0, ep_dma_ack}, 32'h4);
        cyc();
        dma_ack = 1'b0; #1;
        chk("t1_ack_low", {28'd0, ep_dma_ack}, 0);
        ep_dma_req = 4'b0000;
        cyc();
        chk("t1_release_req", {31'd0, dma_req}, 0);
        chk("t1_release_busy", {31'd0, busy}, 1);
        cyc();
        chk("t1_idle_busy", {31'd0, busy}, 0);

        // All requesting, continuous acks: rotation and burst limit
        do_reset();
        ep_dma_req = 4'b1111;
        dma_ack = 1'b1;
        starts = 0; ends = 0; low = 0; acks = 0; prev = 1'b0; exp_ch = '0;
        for (int c = 0; c < 100 && ends < 5; c++) begin
            cyc();
            if (dma_req) begin
                if (!prev) begin
`ifdef USBF_DMA_ARB_EP0_PRIO_EN
                    exp_ch = 4'd0;
`else
                    exp_ch = 4'(starts % 4);
`endif
                    chk("rr_ch", {28'd0, dma_ch}, {28'd0, exp_ch});
                    if (starts > 0) chk("rr_gap", low, 3);
                    starts++;
                    acks = 0;
                end
                chk("rr_ack_route", {28'd0, ep_dma_ack}, 32'd1 << exp_ch);
                acks++;
            end else begin
                if (prev) begin
                    chk("rr_burst_len", acks, 8);
                    ends++;
                    low = 0;
                end
                low++;
            end
            prev = dma_req;
        end
        chk("rr_grants_done", ends, 5);
        dma_ack = 1'b0;

        // Request drop in same cycle as an ack
        do_reset();
        ep_dma_req = 4'b0010;
        cyc();
        chk("t3_grant_ch", {28'd0, dma_ch}, 1);
        cyc();
        dma_ack = 1'b1; ep_dma_req = 4'b0000; #1;
        chk("t3_ack_route", {28'd0, ep_dma_ack}, 32'h2);
        cyc();
        dma_ack = 1'b0; #1;
        chk("t3_release_req", {31'd0, dma_req}, 0);
        chk("t3_release_busy", {31'd0, busy}, 1);
        cyc();
        chk("t3_idle_busy", {31'd0, busy}, 0);

        // Stray acks in IDLE and GRANT must not route or count
        dma_ack = 1'b1; #1;
        chk("t4_idle_stray", {28'd0, ep_dma_ack}, 0);
        ep_dma_req = 4'b0001;
        cyc();
        chk("t4_grant_stray", {28'd0, ep_dma_ack}, 0);
        chk("t4_grant_ch", {28'd0, dma_ch}, 0);
        cyc();
        chk("t4_xfer_route", {28'd0, ep_dma_ack}, 32'h1);
        n = 0;
        while (dma_req && n < 20) begin
            n++;
            cyc();
        end
        chk("t4_full_burst", n, 8);
        dma_ack = 1'b0; ep_dma_req = 4'b0000;
        cyc();

        // Reset mid-transfer at burst_cnt=5
        do_reset();
        ep_dma_req = 4'b1000;
        cyc();
        chk("t5_grant_ch", {28'd0, dma_ch}, 3);
        cyc();
        dma_ack = 1'b1;
        for (int k = 0; k < 5; k++) cyc();
        chk("t5_still_xfer", {31'd0, dma_req}, 1);
        rst = 1'b0; #1;
        chk("t5_rst_req", {31'd0, dma_req}, 0);
        chk("t5_rst_ch", {28'd0, dma_ch}, 0);
        chk("t5_rst_ack", {28'd0, ep_dma_ack}, 0);
        dma_ack = 1'b0; ep_dma_req = 4'b0110;
        cyc();
        rst = 1'b1;
        cyc();
        chk("t5_after_rst_ch", {28'd0, dma_ch}, 1);
        ep_dma_req = 4'b0000;
        cyc();
        cyc();
        cyc();

        // last=0 with ep0 and ep1 requesting
        do_reset();
        ep_dma_req = 4'b0001;
        cyc();
        cyc();
        ep_dma_req = 4'b0000;
        cyc();
        cyc();
        ep_dma_req = 4'b0011;
        cyc();
`ifdef USBF_DMA_ARB_EP0_PRIO_EN
        chk("t6_prio_ch", {28'd0, dma_ch}, 0);
`else
        chk("t6_rr_ch", {28'd0, dma_ch}, 1);
`endif

        // arb_en falling during GRANT
        arb_en = 1'b0;
        cyc();
        chk("t7_xfer_req", {31'd0, dma_req}, 1);
        cyc();
        chk("t7_release_req", {31'd0, dma_req}, 0);
        chk("t7_release_busy", {31'd0, busy}, 1);
        cyc();
        cyc();
        chk("t7_disabled_idle", {31'd0, busy}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
